// File: rtl/mix_pkg.sv
// Shared types and defaults for the multi-channel clip mixer.
package mix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_READ,
        ST_SCALE,
        ST_SUM,
        ST_PLAY
    } state_t;

    localparam int LANE_W     = 16;
    localparam int N_CH_DEF   = 4;
    localparam int GAIN_W_DEF = 8;
    localparam int REPEAT_DEF = 2;

    // Index of the lowest set bit; callers zero-extend their mask to 8 bits.
    function automatic logic [2:0] lowest_set(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mix_lane_sat.sv
// One audio lane: gain scaling of a sample and saturation of the mixed sum.
module mix_lane_sat
    import mix_pkg::*;
#(
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int ACC_W  = LANE_W + 3
) (
    input  logic signed [LANE_W-1:0] sample_i,
    input  logic        [GAIN_W-1:0] gain_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [LANE_W:0]   scaled_o,
    output logic signed [LANE_W-1:0] sat_o
);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (LANE_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (LANE_W - 1)));

    logic signed [LANE_W+GAIN_W:0] product;

    // Gain is Q1.(GAIN_W-1) so the scaled lane can reach nearly twice full scale.
    always_comb begin
        product  = sample_i * $signed({1'b0, gain_i});
        scaled_o = (LANE_W + 1)'(product >>> (GAIN_W - 1));
    end

    always_comb begin
        if (acc_i > MAX_V) begin
            sat_o = 16'sh7FFF;
        end else if (acc_i < MIN_V) begin
            sat_o = -16'sh8000;
        end else begin
            sat_o = acc_i[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/mix_engine.sv
// Clip mixer: fetches per-channel samples from SDRAM, scales, sums with
// saturation and presents each mixed frame REPEAT times on the audio port.
module mix_engine
    import mix_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int ADDR_W = 23,
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int REPEAT = REPEAT_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_CH-1:0]               ch_start,
    input  logic [N_CH-1:0]               ch_stop,
    input  logic [N_CH-1:0][ADDR_W-1:0]   ch_base,
    input  logic [N_CH-1:0][GAIN_W-1:0]   ch_gain,
    output logic                          mix_busy,
    output logic                          mix_done,
    output logic [N_CH-1:0]               ch_active,
    output logic                          mix_read,
    output logic [ADDR_W-1:0]             mix_addr,
    input  logic [31:0]                   mix_readdata,
    input  logic                          mix_sdram_finished,
    output logic                          mix_audio_valid,
    output logic [31:0]                   mix_audio_data,
    input  logic                          mix_audio_ready
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ACC_W = LANE_W + $clog2(N_CH) + 1;
    localparam int RPT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    state_t                  state_q, state_d;
    logic [N_CH-1:0]         pending_q, pending_d, active_q, active_d;
    logic [ADDR_W-1:0]       base_q [N_CH];
    logic [ADDR_W-1:0]       ptr_q  [N_CH];
    logic [ADDR_W-1:0]       end_q  [N_CH];
    logic [31:0]             samp_q [N_CH];
    logic [CH_W-1:0]         cur_ch_q, ch_q, nxt_ch;
    logic                    rd_q;
    logic [ADDR_W-1:0]       addr_q;
    logic signed [ACC_W-1:0] acc_q [2];
    logic [31:0]             data_q;
    logic [RPT_W-1:0]        hs_q;
    logic                    done_q;

    logic [N_CH-1:0]         pend_now, act_now, pend_after, cur_mask;
    logic                    rd_done, len_keep, last_ch, last_hs, launch_len, rd_issue, rd_step;
    logic [ADDR_W-1:0]       len_w;
    logic [31:0]             cur_samp;
    logic signed [LANE_W:0]   scaled [2];
    logic signed [ACC_W-1:0]  scaled_ext [2];
    logic signed [LANE_W-1:0] sat [2];

    assign pend_now   = pending_q & ~ch_stop;
    assign act_now    = active_q & ~ch_stop;
    assign cur_mask   = N_CH'(1) << cur_ch_q;
    assign pend_after = pend_now & ~cur_mask;
    assign rd_done    = rd_q & mix_sdram_finished;
    assign len_w      = mix_readdata[ADDR_W-1:0];
    // A stop during the header read removes the pending bit, so the header is dropped.
    assign len_keep   = pend_now[cur_ch_q];
    assign last_ch    = (ch_q == CH_W'(N_CH - 1));
    assign last_hs    = mix_audio_ready && (hs_q == RPT_W'(REPEAT - 1));
    assign rd_issue   = (state_q == ST_READ) && !rd_q && act_now[ch_q];
    assign rd_step    = (state_q == ST_READ) && (rd_q ? mix_sdram_finished : !act_now[ch_q]);
    assign launch_len = (state_d == ST_LEN) && ((state_q != ST_LEN) || rd_done);
    assign cur_samp   = samp_q[ch_q];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            mix_lane_sat #(.GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_lane (
                .sample_i (cur_samp[31-LANE_W*gi -: LANE_W]),
                .gain_i   (ch_gain[ch_q]),
                .acc_i    (acc_q[gi]),
                .scaled_o (scaled[gi]),
                .sat_o    (sat[gi])
            );
            assign scaled_ext[gi] = {{(ACC_W-LANE_W-1){scaled[gi][LANE_W]}}, scaled[gi]};
        end
    endgenerate

    always_comb begin
        pending_d = pend_now;
        active_d  = act_now;
        if (state_q == ST_LEN && rd_done) begin
            pending_d           = pend_after;
            active_d[cur_ch_q]  = len_keep && (len_w != '0);
        end
        if (rd_step && rd_q && act_now[ch_q] && (ptr_q[ch_q] + ADDR_W'(1) == end_q[ch_q])) begin
            active_d[ch_q] = 1'b0;
        end
        pending_d = pending_d | (ch_start & ~ch_stop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        nxt_ch  = CH_W'(lowest_set(8'(pend_now)));
        case (state_q)
            ST_IDLE:  if (|pend_now) state_d = ST_LEN;
            ST_LEN: begin
                if (rd_done) begin
                    nxt_ch = CH_W'(lowest_set(8'(pend_after)));
                    if (|pend_after)    state_d = ST_LEN;
                    else if (|active_d) state_d = ST_READ;
                    else                state_d = ST_IDLE;
                end
            end
            ST_READ:  if (rd_step && last_ch) state_d = ST_SCALE;
            ST_SCALE: if (last_ch) state_d = ST_SUM;
            ST_SUM:   state_d = ST_PLAY;
            ST_PLAY: begin
                if (last_hs) begin
                    if (|pend_now)     state_d = ST_LEN;
                    else if (|act_now) state_d = ST_READ;
                    else               state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mix_busy        = (state_q != ST_IDLE);
        mix_audio_valid = (state_q == ST_PLAY);
    end

    assign mix_done       = done_q;
    assign ch_active      = active_q;
    assign mix_read       = rd_q;
    assign mix_addr       = rd_q ? addr_q : '0;
    assign mix_audio_data = data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q <= '0;
            active_q  <= '0;
            cur_ch_q  <= '0;
            ch_q      <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            hs_q      <= '0;
            done_q    <= 1'b0;
            acc_q[0]  <= '0;
            acc_q[1]  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                base_q[i] <= '0;
                ptr_q[i]  <= '0;
                end_q[i]  <= '0;
                samp_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            done_q    <= (state_d == ST_IDLE) && (state_q == ST_LEN || state_q == ST_PLAY);
            for (int i = 0; i < N_CH; i++) begin
                if (ch_start[i]) base_q[i] <= ch_base[i];
            end
            if (rd_done) rd_q <= 1'b0;
            if (state_q == ST_LEN && rd_done && len_keep) begin
                ptr_q[cur_ch_q] <= addr_q + ADDR_W'(1);
                end_q[cur_ch_q] <= addr_q + ADDR_W'(1) + len_w;
            end
            if (launch_len) begin
                cur_ch_q <= nxt_ch;
                addr_q   <= base_q[nxt_ch];
                rd_q     <= 1'b1;
            end
            if (rd_issue) begin
                addr_q <= ptr_q[ch_q];
                rd_q   <= 1'b1;
            end
            // Data of a channel stopped mid-read is replaced by silence.
            if (rd_step) begin
                samp_q[ch_q] <= (rd_q && act_now[ch_q]) ? mix_readdata : '0;
                if (rd_q && act_now[ch_q]) ptr_q[ch_q] <= ptr_q[ch_q] + ADDR_W'(1);
                ch_q <= last_ch ? '0 : ch_q + CH_W'(1);
            end
            if (state_q == ST_SCALE) begin
                for (int l = 0; l < 2; l++) begin
                    acc_q[l] <= ((ch_q == '0) ? '0 : acc_q[l]) + scaled_ext[l];
                end
                ch_q <= last_ch ? '0 : ch_q + CH_W'(1);
            end
            if (state_q == ST_SUM) data_q <= {sat[0], sat[1]};
            if (state_q == ST_PLAY && mix_audio_ready) hs_q <= last_hs ? '0 : hs_q + RPT_W'(1);
        end
    end

endmodule

// File: tb/tb_mix_engine.sv
// Directed bench for mix_engine with an SDRAM responder and scoreboarded audio sink.
module tb_mix_engine;
    localparam int N_CH   = 4;
    localparam int ADDR_W = 23;
    localparam int GAIN_W = 8;
    localparam int REPEAT = 2;

    logic                        clk;
    logic                        i_rst;
    logic [N_CH-1:0]             ch_start, ch_stop;
    logic [N_CH-1:0][ADDR_W-1:0] ch_base;
    logic [N_CH-1:0][GAIN_W-1:0] ch_gain;
    logic                        mix_busy, mix_done, mix_read;
    logic [N_CH-1:0]             ch_active;
    logic [ADDR_W-1:0]           mix_addr;
    logic [31:0]                 mix_readdata;
    logic                        mix_sdram_finished;
    logic                        mix_audio_valid, mix_audio_ready;
    logic [31:0]                 mix_audio_data;

    int checks = 0;
    int errors = 0;
    int hs_total = 0;
    int done_cnt = 0;
    logic mon_en = 1'b0;
    logic [31:0] sb [$];
    logic [31:0] mem [int];
    logic [ADDR_W-1:0] hold_addr;

    mix_engine #(.N_CH(N_CH), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W), .REPEAT(REPEAT)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .ch_start           (ch_start),
        .ch_stop            (ch_stop),
        .ch_base            (ch_base),
        .ch_gain            (ch_gain),
        .mix_busy           (mix_busy),
        .mix_done           (mix_done),
        .ch_active          (ch_active),
        .mix_read           (mix_read),
        .mix_addr           (mix_addr),
        .mix_readdata       (mix_readdata),
        .mix_sdram_finished (mix_sdram_finished),
        .mix_audio_valid    (mix_audio_valid),
        .mix_audio_data     (mix_audio_data),
        .mix_audio_ready    (mix_audio_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // SDRAM model: answers each read after three cycles, except at hold_addr.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mix_sdram_finished = 1'b0;
        mix_readdata = '0;
        forever begin
            @(negedge clk);
            mix_sdram_finished = 1'b0;
            mix_readdata = '0;
            if (mix_read === 1'b1 && mix_addr !== hold_addr) begin
                if (wait_cnt == 2) begin
                    mix_sdram_finished = 1'b1;
                    mix_readdata = mem.exists(int'(mix_addr)) ? mem[int'(mix_addr)] : 32'h0;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Audio sink: random back-pressure, every handshake popped from the scoreboard.
    initial begin
        logic [31:0] exp_w;
        mix_audio_ready = 1'b0;
        forever begin
            @(negedge clk);
            mix_audio_ready = ($urandom_range(0, 3) != 0);
            if (mon_en) begin
                if (mix_audio_valid === 1'b1 && mix_audio_ready) begin
                    hs_total++;
                    $display("HS %0d data=%h", hs_total, mix_audio_data);
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL sb_underflow observed=%h expected=no_handshake", mix_audio_data);
                    end
                    if (sb.size() != 0) begin
                        exp_w = sb.pop_front();
                        checks++;
                        assert (mix_audio_data === exp_w) else begin
                            errors++;
                            $error("FAIL audio_data observed=%h expected=%h", mix_audio_data, exp_w);
                        end
                    end
                end
                checks++;
                assert ({mix_read & mix_audio_valid, (mix_read ? 23'h0 : mix_addr)} === 24'h0) else begin
                    errors++;
                    $error("FAIL bus_excl observed=rd%b/val%b/addr%h expected=exclusive,addr0",
                           mix_read, mix_audio_valid, mix_addr);
                end
                if (mix_done === 1'b1) done_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse(input logic [N_CH-1:0] st, input logic [N_CH-1:0] sp);
        @(negedge clk);
        ch_start = st;
        ch_stop  = sp;
        @(negedge clk);
        ch_start = '0;
        ch_stop  = '0;
    endtask

    task automatic push_frames(input logic [31:0] w, input int frames);
        repeat (frames * REPEAT) sb.push_back(w);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (mix_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'h0, mix_done}, 32'h1);
        chk({tag, "_idle"}, {31'h0, mix_busy}, 32'h0);
        repeat (2) @(negedge clk);
        chk({tag, "_sb_empty"}, sb.size(), 32'h0);
    endtask

    initial begin
        int n;
        int hs0;
        i_rst = 1'b1;
        ch_start = '0;
        ch_stop = '0;
        ch_base = '0;
        ch_gain = '0;
        hold_addr = '1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_busy",   {31'h0, mix_busy}, 32'h0);
        chk("rst_done",   {31'h0, mix_done}, 32'h0);
        chk("rst_read",   {31'h0, mix_read}, 32'h0);
        chk("rst_addr",   {9'h0, mix_addr}, 32'h0);
        chk("rst_valid",  {31'h0, mix_audio_valid}, 32'h0);
        chk("rst_data",   mix_audio_data, 32'h0);
        chk("rst_active", {28'h0, ch_active}, 32'h0);
        i_rst = 1'b0;

        // Single channel, three samples at unity gain.
        mem[32'h100] = 32'd3;
        for (int a = 32'h101; a <= 32'h103; a++) mem[a] = 32'h1000_F000;
        ch_base[0] = 23'h100;
        ch_gain[0] = 8'h80;
        push_frames(32'h1000_F000, 3);
        pulse(4'b0001, 4'b0000);
        wait_done("t1", 3000);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_active", {28'h0, ch_active}, 32'h0);

        // Two channels of different length; channel 1 at gain 1.5.
        mem[32'h200] = 32'd2;
        mem[32'h201] = 32'h0100_0200;
        mem[32'h202] = 32'h0100_0200;
        mem[32'h300] = 32'd1;
        mem[32'h301] = 32'h0010_FFF0;
        ch_base[0] = 23'h200;
        ch_base[1] = 23'h300;
        ch_gain[1] = 8'hC0;
        push_frames(32'h0118_01E8, 1);
        push_frames(32'h0100_0200, 1);
        pulse(4'b0011, 4'b0000);
        wait_done("t2", 3000);
        chk("t2_done_cnt", done_cnt, 32'd2);

        // Positive and negative saturation.
        mem[32'h400] = 32'd1;
        mem[32'h401] = 32'h7000_7000;
        mem[32'h480] = 32'd1;
        mem[32'h481] = 32'h7000_7000;
        ch_base[0] = 23'h400;
        ch_base[1] = 23'h480;
        ch_gain[1] = 8'h80;
        push_frames(32'h7FFF_7FFF, 1);
        pulse(4'b0011, 4'b0000);
        wait_done("t3", 3000);
        mem[32'h401] = 32'h9000_9000;
        mem[32'h481] = 32'h9000_9000;
        push_frames(32'h8000_8000, 1);
        pulse(4'b0011, 4'b0000);
        wait_done("t4", 3000);
        chk("t4_done_cnt", done_cnt, 32'd4);

        // Half gain on channel 2.
        mem[32'h500] = 32'd1;
        mem[32'h501] = 32'h0100_FF00;
        ch_base[2] = 23'h500;
        ch_gain[2] = 8'h40;
        push_frames(32'h0080_FF80, 1);
        pulse(4'b0100, 4'b0000);
        wait_done("t5", 3000);

        // Zero-length clip never becomes active.
        mem[32'h600] = 32'd0;
        ch_base[3] = 23'h600;
        ch_gain[3] = 8'h80;
        hs0 = hs_total;
        pulse(4'b1000, 4'b0000);
        wait_done("t6", 3000);
        chk("t6_no_audio", hs_total, hs0);
        chk("t6_active", {28'h0, ch_active}, 32'h0);
        chk("t6_done_cnt", done_cnt, 32'd6);

        // Simultaneous start and stop on channel 1 while channel 0 plays.
        mem[32'h800] = 32'd4;
        for (int a = 32'h801; a <= 32'h804; a++) mem[a] = 32'h1234_F234;
        mem[32'h880] = 32'd2;
        mem[32'h881] = 32'h0101_0101;
        mem[32'h882] = 32'h0101_0101;
        ch_base[0] = 23'h800;
        ch_base[1] = 23'h880;
        push_frames(32'h1234_F234, 4);
        pulse(4'b0001, 4'b0000);
        repeat (3) @(negedge clk);
        pulse(4'b0010, 4'b0010);
        repeat (4) @(negedge clk);
        chk("t7_ch_active", {28'h0, ch_active}, 32'h1);
        wait_done("t7", 3000);
        chk("t7_done_cnt", done_cnt, 32'd7);

        // Reset while a sample read is stalled.
        mem[32'h900] = 32'd5;
        ch_base[0] = 23'h900;
        hold_addr = 23'h901;
        pulse(4'b0001, 4'b0000);
        n = 0;
        while (!(mix_read === 1'b1 && mix_addr === 23'h901) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t8_read_held", {8'h0, mix_read, mix_addr}, {8'h0, 1'b1, 23'h901});
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        chk("t8_read",   {31'h0, mix_read}, 32'h0);
        chk("t8_busy",   {31'h0, mix_busy}, 32'h0);
        chk("t8_active", {28'h0, ch_active}, 32'h0);
        chk("t8_data",   mix_audio_data, 32'h0);
        i_rst = 1'b0;
        hold_addr = '1;
        repeat (4) @(negedge clk);
        chk("t8_stay_idle", {31'h0, mix_busy}, 32'h0);
        chk("t8_sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
